ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch front end. Generates sequential PCs, issues requests to instruction memory, and buffers the returned words in an in-order FIFO.
- Presents a valid/ready instruction stream (instruction word plus its PC) to the decode stage, which extracts op[6:0] for the main decoder.
- Accepts redirects from branch/jump resolution. A redirect flushes buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2; also bounds outstanding requests plus occupancy.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address, word-aligned.
- imem_rsp_valid  in  1  response valid; in request order, latency >= 1 cycle, unbounded.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  32  instruction word.
- inst_pc  out  32  PC of inst_data.

Behaviour:
- Reset (clk edge with rst=1): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
- Reset mid-operation discards everything, including responses still in flight. The bench must not return stale responses after reset.
- Credit rule: imem_req_valid=1 iff (count + outstanding) < DEPTH and redirect_valid=0.
- imem_addr = fetch_pc.
- Request handshake: on imem_req_valid & imem_req_ready, fetch_pc += 4 (wraps at 2^32) and outstanding += 1.
- Request PCs are pushed into a DEPTH-entry pc-tag queue, so each response is paired with its PC.
- Response, discard=0: write {data, tagged pc} into the FIFO and decrement outstanding.
- Response, discard>0: drop the word and its tag, decrement discard and outstanding. The FIFO is not written.
- Output: inst_valid = FIFO non-empty; inst_data/inst_pc = head entry (registered storage).
- Pop on inst_valid & inst_ready.
- Simultaneous push and pop while full is legal. Full cannot overflow, guaranteed by the credit rule.
- Redirect (cycle with redirect_valid=1):
  - Next cycle: FIFO empty, fetch_pc = {redirect_pc[31:2],2'b00}, discard = outstanding after this cycle's response accounting.
  - A request handshake in the redirect cycle is impossible (req_valid=0).
  - A response arriving in the redirect cycle is dropped.
  - inst_valid is 0 the cycle after the redirect.
  - A pop in the redirect cycle is permitted but the entry is flushed anyway.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Latency: request accept to inst_valid = memory latency + 1 cycle (FIFO register).
- Throughput: 1 instruction/cycle sustained when memory latency < DEPTH.
- No combinational path from inst_ready to imem_req_valid beyond the credit count (count updates registered).

Optional Feature:
- IFQ_BYPASS_EN defined: when the FIFO is empty, discard=0, a response arrives and inst_ready=1, the word is presented combinationally (inst_valid=1, inst_data=imem_rsp_data, inst_pc=tag head) and consumed without a FIFO write. This gives zero added latency.
- Undefined: all responses pass through the FIFO (+1 cycle); outputs are purely registered.

Test Plan:
- Reset, imem_req_ready=1, 2-cycle memory, inst_ready=1 -> addresses 0,4,8,... issued each cycle; inst_pc 0,4,8 in order with matching data; one instruction per cycle after the pipeline fills.
- inst_ready=0 for 10 cycles -> exactly DEPTH(4) requests outstanding/buffered, imem_req_valid=0, no overflow. Release -> 4 instructions out in order, then fetching resumes.
- Redirect to 0x100 with 3 responses in flight -> those 3 dropped, next inst_pc=0x100, then 0x104; no stale PC ever appears.
- redirect_pc=0x203 -> imem_addr=0x200.
- Back-to-back redirects 0x40 then 0x80 -> first instruction delivered has inst_pc=0x80.
- rst asserted mid-stream -> next cycle inst_valid=0, imem_addr=RESET_PC.
- imem_req_ready toggling randomly, memory latency 1-5 cycles -> PC/data pairing stays correct. With IFQ_BYPASS_EN, latency from response to consumption is 0 cycles when empty.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch: sequential PC generator, pc-tag queue and in-order
// instruction FIFO. Define IFQ_BYPASS_EN to forward responses when empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [31:0] pcs_q [DEPTH];
  ptr_t        twp_q, twp_d, trp_q, trp_d;
  ptr_t        wp_q, wp_d, rp_q, rp_d;
  cnt_t        out_q, out_d;
  cnt_t        disc_q, disc_d;
  cnt_t        cnt_q, cnt_d;

  logic req_fire;
  logic keep;
  logic pop;
  logic fifo_valid;
  logic byp;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Credit covers both buffered words and words still in flight.
  assign imem_req_valid = !rst && !redirect_valid &&
                          ((cnt_q + out_q) < DEPTH_C);
  assign imem_addr  = pc_q;
  assign req_fire   = imem_req_valid && imem_req_ready;
  assign fifo_valid = (cnt_q != '0);
  assign pop        = fifo_valid && inst_ready;

`ifdef IFQ_BYPASS_EN
  assign byp = (cnt_q == '0) && (disc_q == '0) && imem_rsp_valid &&
               inst_ready && !redirect_valid;
  assign inst_valid = fifo_valid || byp;
  assign inst_data  = byp ? imem_rsp_data : dat_q[rp_q];
  assign inst_pc    = byp ? tag_q[trp_q] : pcs_q[rp_q];
`else
  assign byp        = 1'b0;
  assign inst_valid = fifo_valid;
  assign inst_data  = dat_q[rp_q];
  assign inst_pc    = pcs_q[rp_q];
`endif

  assign keep = imem_rsp_valid && (disc_q == '0) &&
                !redirect_valid && !byp;

  always_comb begin
    pc_d   = pc_q;
    twp_d  = twp_q;
    trp_d  = trp_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    disc_d = disc_q;
    if (req_fire) begin
      pc_d  = pc_q + 32'd4;
      twp_d = twp_q + ptr_t'(1);
    end
    if (imem_rsp_valid) begin
      trp_d = trp_q + ptr_t'(1);
    end
    out_d = out_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
    if (imem_rsp_valid && (disc_q != '0)) begin
      disc_d = disc_q - cnt_t'(1);
    end
    if (keep) wp_d = wp_q + ptr_t'(1);
    if (pop)  rp_d = rp_q + ptr_t'(1);
    cnt_d = cnt_q + cnt_t'(keep) - cnt_t'(pop);
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      disc_d = out_d;
      cnt_d  = '0;
      wp_d   = '0;
      rp_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      twp_q  <= '0;
      trp_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      out_q  <= '0;
      disc_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        dat_q[i] <= '0;
        pcs_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      if (req_fire) begin
        tag_q[twp_q] <= pc_q;
      end
      if (keep) begin
        dat_q[wp_q] <= imem_rsp_data;
        pcs_q[wp_q] <= tag_q[trp_q];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order variable-latency
// instruction memory model and a delivery monitor.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

`ifdef IFQ_BYPASS_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 1;
`endif

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int pass = 0;
  int ecnt = 0;
  int lmin = 2;
  int lmax = 2;
  bit rrand = 1'b0;
  int iss_cnt = 0;
  int del_cnt = 0;
  logic [31:0] mq_a[$];
  int          mq_d[$];
  logic [31:0] iss_a[$];
  int          iss_e[$];
  logic [31:0] got_p[$];
  logic [31:0] got_d[$];
  int          got_e[$];
  logic [31:0] nxt = '0;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory: decides at negedge what happens on the next rising edge.
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      ecnt++;
      imem_req_ready = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (rst) begin
        mq_a.delete();
        mq_d.delete();
      end else begin
        if (mq_a.size() > 0 && mq_d[0] <= ecnt) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = dfun(mq_a[0]);
          void'(mq_a.pop_front());
          void'(mq_d.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
          mq_a.push_back(imem_addr);
          mq_d.push_back(ecnt + int'($urandom_range(lmax, lmin)));
          iss_a.push_back(imem_addr);
          iss_e.push_back(ecnt);
          iss_cnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && !redirect_valid && inst_valid && inst_ready) begin
        got_p.push_back(inst_pc);
        got_d.push_back(inst_data);
        got_e.push_back(ecnt);
        del_cnt++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    smp();
    chk++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    else pass++;
    chk++;
    if (imem_addr !== 32'h0)
      $display("FAIL rst_addr: got %h want 0", imem_addr);
    else pass++;
    chk++;
    if (inst_valid !== 1'b0)
      $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    else pass++;
    chk++;
    if (inst_data !== 32'h0)
      $display("FAIL rst_inst_data: got %h want 0", inst_data);
    else pass++;
    chk++;
    if (inst_pc !== 32'h0)
      $display("FAIL rst_inst_pc: got %h want 0", inst_pc);
    else pass++;
  endtask

  task automatic test_stream();
    lmin = 2;
    lmax = 2;
    inst_ready = 1'b1;
    cyc(1);
    rst = 1'b0;
    got_p.delete(); got_d.delete(); got_e.delete();
    iss_a.delete(); iss_e.delete();
    iss_cnt = 0;
    del_cnt = 0;
    nxt = 32'h0;
    cyc(20);
    for (int i = 0; i < 10 && i < iss_a.size(); i++) begin
      chk++;
      if (iss_a[i] !== 32'(4 * i))
        $display("FAIL stream_addr[%0d]: got %h want %h",
                 i, iss_a[i], 32'(4 * i));
      else pass++;
      if (i > 0) begin
        chk++;
        if (iss_e[i] !== iss_e[i-1] + 1)
          $display("FAIL stream_issue_gap[%0d]: got %0d want %0d",
                   i, iss_e[i] - iss_e[i-1], 1);
        else pass++;
      end
    end
    chk++;
    if (got_p.size() < 10) begin
      $display("FAIL stream_count: got %0d want >=10", got_p.size());
    end else begin
      pass++;
      chk++;
      if (got_e[0] - iss_e[0] !== 2 + EXTRA)
        $display("FAIL stream_latency: got %0d want %0d",
                 got_e[0] - iss_e[0], 2 + EXTRA);
      else pass++;
      for (int i = 1; i < 10; i++) begin
        chk++;
        if (got_e[i] !== got_e[i-1] + 1)
          $display("FAIL stream_gap[%0d]: got %0d want 1",
                   i, got_e[i] - got_e[i-1]);
        else pass++;
      end
    end
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL stream_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      chk++;
      if (got_d[i] !== dfun(nxt))
        $display("FAIL stream_data[%0d]: got %h want %h",
                 i, got_d[i], dfun(nxt));
      else pass++;
      nxt += 32'd4;
    end
    got_p.delete(); got_d.delete(); got_e.delete();
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    cyc(10);
    smp();
    chk++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL bp_req_valid: got %b want 0", imem_req_valid);
    else pass++;
    chk++;
    if (iss_cnt - del_cnt !== 4)
      $display("FAIL bp_in_queue: got %0d want 4", iss_cnt - del_cnt);
    else pass++;
    chk++;
    if (got_p.size() !== 0)
      $display("FAIL bp_no_pop: got %0d want 0", got_p.size());
    else pass++;
    cyc(1);
    inst_ready = 1'b1;
    cyc(10);
    chk++;
    if (got_p.size() < 6)
      $display("FAIL bp_resume: got %0d want >=6", got_p.size());
    else pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL bp_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      chk++;
      if (got_d[i] !== dfun(nxt))
        $display("FAIL bp_data[%0d]: got %h want %h",
                 i, got_d[i], dfun(nxt));
      else pass++;
      nxt += 32'd4;
    end
    got_p.delete(); got_d.delete(); got_e.delete();
  endtask

  task automatic test_redirect(input logic [31:0] tgt,
                               input logic [31:0] exp_pc);
    lmin = 3;
    lmax = 3;
    inst_ready = 1'b1;
    cyc(6);
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL redir_pre_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      nxt += 32'd4;
    end
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    cyc(1);
    redirect_valid = 1'b0;
    got_p.delete(); got_d.delete(); got_e.delete();
    smp();
    chk++;
    if (inst_valid !== 1'b0)
      $display("FAIL redir_flush: got %b want 0", inst_valid);
    else pass++;
    chk++;
    if (imem_addr !== exp_pc)
      $display("FAIL redir_addr: got %h want %h", imem_addr, exp_pc);
    else pass++;
    cyc(12);
    nxt = exp_pc;
    chk++;
    if (got_p.size() < 3)
      $display("FAIL redir_count: got %0d want >=3", got_p.size());
    else pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL redir_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      chk++;
      if (got_d[i] !== dfun(nxt))
        $display("FAIL redir_data[%0d]: got %h want %h",
                 i, got_d[i], dfun(nxt));
      else pass++;
      nxt += 32'd4;
    end
    got_p.delete(); got_d.delete(); got_e.delete();
  endtask

  task automatic test_back_to_back();
    lmin = 2;
    lmax = 4;
    cyc(4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cyc(1);
    redirect_pc = 32'h80;
    cyc(1);
    redirect_valid = 1'b0;
    got_p.delete(); got_d.delete(); got_e.delete();
    smp();
    chk++;
    if (imem_addr !== 32'h80)
      $display("FAIL b2b_addr: got %h want 00000080", imem_addr);
    else pass++;
    cyc(14);
    nxt = 32'h80;
    chk++;
    if (got_p.size() < 2)
      $display("FAIL b2b_count: got %0d want >=2", got_p.size());
    else pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL b2b_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      chk++;
      if (got_d[i] !== dfun(nxt))
        $display("FAIL b2b_data[%0d]: got %h want %h",
                 i, got_d[i], dfun(nxt));
      else pass++;
      nxt += 32'd4;
    end
    got_p.delete(); got_d.delete(); got_e.delete();
  endtask

  task automatic test_reset_mid();
    lmin = 3;
    lmax = 3;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    smp();
    chk++;
    if (inst_valid !== 1'b0)
      $display("FAIL rmid_inst_valid: got %b want 0", inst_valid);
    else pass++;
    chk++;
    if (imem_addr !== 32'h0)
      $display("FAIL rmid_addr: got %h want 0", imem_addr);
    else pass++;
    chk++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL rmid_req_valid: got %b want 0", imem_req_valid);
    else pass++;
    cyc(1);
    rst = 1'b0;
    got_p.delete(); got_d.delete(); got_e.delete();
    cyc(12);
    nxt = 32'h0;
    chk++;
    if (got_p.size() < 3)
      $display("FAIL rmid_count: got %0d want >=3", got_p.size());
    else pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL rmid_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      nxt += 32'd4;
    end
    got_p.delete(); got_d.delete(); got_e.delete();
  endtask

  task automatic test_random();
    lmin = 1;
    lmax = 5;
    rrand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    rrand = 1'b0;
    inst_ready = 1'b1;
    cyc(20);
    chk++;
    if (got_p.size() < 40)
      $display("FAIL rand_count: got %0d want >=40", got_p.size());
    else pass++;
    for (int i = 0; i < got_p.size(); i++) begin
      chk++;
      if (got_p[i] !== nxt)
        $display("FAIL rand_pc[%0d]: got %h want %h", i, got_p[i], nxt);
      else pass++;
      chk++;
      if (got_d[i] !== dfun(nxt))
        $display("FAIL rand_data[%0d]: got %h want %h",
                 i, got_d[i], dfun(nxt));
      else pass++;
      nxt += 32'd4;
    end
    got_p.delete(); got_d.delete(); got_e.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(32'h100, 32'h100);
    test_redirect(32'h203, 32'h200);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
